// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and sizes for the unified memory port arbiter
package mips_mem_pkg;

  localparam int MEM_ADDR_W = 10;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    DBG_ACC = 2'd2
  } mem_arb_state_t;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DBG = 1'b1
  } mem_port_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - CPU/debug round-robin arbiter for the single-ported MIPS memory
// MEM_ARB_LOADER_EN: when defined, the debug port may write (program loader).
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  mem_arb_state_t    state;
  mem_port_t         last_grant;
  logic              wr_flag;
  logic [ADDR_W-1:0] addr_q;
  logic              cpu_pend;
  logic              dbg_pend;
  logic              pick_cpu;
  logic              dbg_wr;

  // A request is not re-taken in the cycle that carries its own ack.
  assign cpu_pend = cpu_req & ~cpu_ack;
  assign dbg_pend = dbg_req & ~dbg_ack;
  assign pick_cpu = cpu_pend & (~dbg_pend | (last_grant == PORT_DBG));

`ifdef MEM_ARB_LOADER_EN
  assign dbg_wr = dbg_we;
`else
  logic unused_dbg_we;
  assign unused_dbg_we = dbg_we;
  assign dbg_wr        = 1'b0;
`endif

  assign mem_addr = {{(32-ADDR_W){1'b0}}, addr_q};
  // Gating with rst_n suppresses a write already in flight when reset hits.
  assign mem_we   = (state != IDLE) & wr_flag & rst_n;
  assign mem_re   = (state != IDLE) & ~wr_flag & rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= PORT_DBG;
      cpu_ack    <= 1'b0;
      dbg_ack    <= 1'b0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
      addr_q     <= '0;
      mem_wdata  <= '0;
      wr_flag    <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_cpu) begin
            state      <= CPU_ACC;
            last_grant <= PORT_CPU;
            addr_q     <= cpu_addr;
            mem_wdata  <= cpu_wdata;
            wr_flag    <= cpu_we;
          end else if (dbg_pend) begin
            state      <= DBG_ACC;
            last_grant <= PORT_DBG;
            addr_q     <= dbg_addr;
            mem_wdata  <= dbg_wdata;
            wr_flag    <= dbg_wr;
          end
        end
        CPU_ACC: begin
          if (!wr_flag) cpu_rdata <= mem_rdata;
          cpu_ack <= 1'b1;
          state   <= IDLE;
        end
        DBG_ACC: begin
          if (!wr_flag) dbg_rdata <= mem_rdata;
          dbg_ack <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port arbiter and sequencer in front of the single-ported unified instruction/data memory of the multicycle MIPS. It shares the memory between the CPU port (multicycle control unit, instruction fetch and load/store) and a debug/loader port (board switches, program loader). Each accepted request becomes exactly one memory access with a registered response and a one-cycle acknowledge. The memory's synchronous write and combinational, `re`-gated read are never driven from both sources at once.

## Interface
- `ADDR_W`, 10: word-address width; memory depth 2^ADDR_W words.
- `DATA_W`, 32: data word width.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cpu_req`  in  1  CPU access request, level, held until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read; stable while `cpu_req` is high.
- `cpu_addr`  in  ADDR_W  CPU word address.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  DATA_W  read data, valid while `cpu_ack` is high, held until the next CPU read completes.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_ack`, `dbg_rdata`: same signals and rules for the debug/loader port.
- `mem_addr`  out  32  memory address, zero-extended from ADDR_W.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_we`  out  1  memory write enable.
- `mem_re`  out  1  memory read enable; memory read data is high-Z when this is low.
- `mem_rdata`  in  DATA_W  memory read data, combinational from `mem_addr`.

## Operation
- States are IDLE, CPU_ACC and DBG_ACC.
- IDLE:
  - A request is sampled at the rising edge.
  - Only the CPU requesting → go to CPU_ACC.
  - Only debug requesting → go to DBG_ACC.
  - Both requesting → round-robin on `last_grant`: the port not granted last wins. `last_grant` resets to DBG, so the CPU wins the first tie.
  - On a grant, address, data and write bit are latched into `mem_addr`, `mem_wdata` and an internal write flag. `last_grant` is updated.
- X_ACC:
  - Writes: `mem_we = wr_flag & rst_n`.
  - Reads: `mem_re = ~wr_flag & rst_n`.
  - At the end of the cycle a read captures `mem_rdata` into that port's `rdata` register.
  - The port's `ack` is set for the next cycle, and the state returns to IDLE unconditionally.
- Request handling:
  - A port's `req` is ignored in the cycle its `ack` is high; the requester drops it there.
  - A new request from the same port is honoured from the following cycle.
  - Writes return `ack` with `rdata` unchanged.
- Addresses ≥ 2^ADDR_W are not possible; `mem_addr[31:ADDR_W]` = 0.
- Reset values: state IDLE, `last_grant` DBG, all `ack`s 0, all `rdata` 0, `mem_addr` 0, `mem_wdata` 0, `mem_we` 0, `mem_re` 0.
- Reset mid-access: a write in progress during a cycle with `rst_n` low is suppressed, so the memory is unchanged. No `ack` is issued, and the state goes to IDLE.

## Timing
- Request sampled at edge k (IDLE) → access cycle k+1 → `ack` and `rdata` valid in cycle k+2.
- Best case: 2-cycle latency per access.
- Throughput: one access per 2 cycles. The IDLE cycle that carries the `ack` can already accept the other port's request.
- Contention, both ports requesting continuously: grants strictly alternate, and neither port waits more than 4 cycles for `ack`.
- `mem_we` and `mem_re` are each high for exactly one cycle per access and are never high together.
- `mem_re` is low in IDLE, so nothing samples a high-Z `mem_rdata`.

## Configuration
- `MEM_ARB_LOADER_EN` defined:
  - The debug port may write (`dbg_we` honoured).
  - Used for loading programs on the board.
- Not defined:
  - `dbg_we` is ignored and every debug access is a read.
  - The access is still acked, with `dbg_rdata` updated from the read.
  - `mem_we` is never driven from the debug port.

## Structure
- Package `mips_mem_pkg`: state enum `mem_arb_state_t` (IDLE, CPU_ACC, DBG_ACC), port-id enum (`PORT_CPU`, `PORT_DBG`), `MEM_ADDR_W` = 10, `MEM_DATA_W` = 32.
- Single module; no sub-module. The round-robin pick is a few lines inside the IDLE decode.

## Test plan
- CPU write 0x12345678 to address 5, then CPU read of address 5 → `mem_we` high exactly one cycle, first `cpu_ack` at k+2, second `cpu_ack` with `cpu_rdata` = 0x12345678.
- After reset, CPU read of address 3 and debug read of address 4 raised in the same cycle → CPU granted first with `cpu_ack` at k+2; `dbg_ack` follows 2 cycles later with the word at address 4.
- Both ports requesting continuously for 8 accesses → `ack`s alternate CPU, DBG, CPU, …; no port has two consecutive grants while the other waits.
- Debug write of 0xDEADBEEF to address 0x3FF, then CPU read of address 0x3FF:
  - With `MEM_ARB_LOADER_EN`: the CPU reads 0xDEADBEEF.
  - Without it: `dbg_ack` still pulses, `mem_we` stays 0 and the CPU reads the old value.
- `rst_n` driven low during CPU_ACC of a write of 0xAAAA5555 → `mem_we` is 0 that cycle, no `cpu_ack`, state IDLE, and the target word is unchanged.
- No requests for 10 cycles → `mem_we` = `mem_re` = 0, `ack`s 0, `rdata` registers hold their last values.
